// File: rtl/decade_chain_controller_pkg.sv
// rtl/decade_chain_controller_pkg.sv - shared state encoding and BCD helpers for the decade chain controller
package decade_chain_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } chain_state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    function automatic logic bcd_digit_valid(input logic [3:0] nibble);
        return nibble <= BCD_NINE;
    endfunction

endpackage

// File: rtl/decade_chain_controller_if.sv
// rtl/decade_chain_controller_if.sv - control and cell-chain signals of the decade chain controller
interface decade_chain_controller_if #(
    parameter int NUM_DIGITS     = 2,
    parameter int PRESCALE_WIDTH = 8
);
    logic                        start;
    logic                        stop;
    logic [PRESCALE_WIDTH-1:0]   prescale_value;
    logic [4*NUM_DIGITS-1:0]     target_bcd;
    logic [4*NUM_DIGITS-1:0]     digit_values;
    logic [NUM_DIGITS-1:0]       digit_enable;
    logic [NUM_DIGITS-1:0]       digit_reset;
    logic                        busy;
    logic                        done;

    // master: surrounding control logic plus the cell chain; slave: the controller
    modport master (
        output start, stop, prescale_value, target_bcd, digit_values,
        input  digit_enable, digit_reset, busy, done
    );

    modport slave (
        input  start, stop, prescale_value, target_bcd, digit_values,
        output digit_enable, digit_reset, busy, done
    );
endinterface

// File: rtl/decade_chain_controller_carry.sv
// rtl/decade_chain_controller_carry.sv - BCD ripple-carry decode for a chain of non-wrapping decade cells
module decade_carry_logic
    import decade_chain_controller_pkg::*;
#(
    parameter int NUM_DIGITS = 2
) (
    input  logic                    tick,
    input  logic [4*NUM_DIGITS-1:0] digit_values,
    output logic [NUM_DIGITS-1:0]   digit_enable,
    output logic [NUM_DIGITS-1:0]   digit_reset
);

    // The cells count past 9, so a carried-into nine is cleared instead of incremented.
    always_comb begin : carry_chain
        logic carry;
        carry        = tick;
        digit_enable = '0;
        digit_reset  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (digit_values[4*i +: 4] == BCD_NINE) begin
                    digit_reset[i] = 1'b1;
                end else begin
                    digit_enable[i] = 1'b1;
                end
            end
            carry = carry && (digit_values[4*i +: 4] == BCD_NINE);
        end
    end

endmodule

// File: rtl/decade_chain_controller.sv
// rtl/decade_chain_controller.sv - clears, prescales and steps a BCD decade cell chain up to a target value
module decade_chain_controller
    import decade_chain_controller_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                     control_clock,
    input  logic                     control_counter_reset,
    decade_chain_controller_if.slave bus
);

    chain_state_t              state;
    logic [PRESCALE_WIDTH-1:0] prescaler;
    logic [PRESCALE_WIDTH-1:0] prescale_latched;
    logic [4*NUM_DIGITS-1:0]   target_latched;
    logic                      busy_r;
    logic                      done_r;

    logic                      target_valid;
    logic                      target_match;
    logic                      tick;
    logic                      count_tick;
    logic [NUM_DIGITS-1:0]     carry_enable;
    logic [NUM_DIGITS-1:0]     carry_reset;

    // A target holding a non-BCD nibble can never be reached, even by a faulty cell.
    always_comb begin
        target_valid = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            target_valid = target_valid && bcd_digit_valid(target_latched[4*i +: 4]);
        end
    end

    assign target_match = target_valid && (bus.digit_values == target_latched);
    assign tick         = (prescaler == prescale_latched);
    assign count_tick   = (state == ST_RUN) && !bus.stop && !target_match
                          && !control_counter_reset && tick;

    decade_carry_logic #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_carry (
        .tick         (count_tick),
        .digit_values (bus.digit_values),
        .digit_enable (carry_enable),
        .digit_reset  (carry_reset)
    );

    assign bus.digit_enable = carry_enable;
    assign bus.digit_reset  = (control_counter_reset || state == ST_CLEAR) ? '1 : carry_reset;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;

    always_ff @(negedge control_clock) begin
        if (control_counter_reset) begin
            state            <= ST_IDLE;
            prescaler        <= '0;
            prescale_latched <= '0;
            target_latched   <= '0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state            <= ST_CLEAR;
                        prescale_latched <= bus.prescale_value;
                        target_latched   <= bus.target_bcd;
                        prescaler        <= '0;
                        busy_r           <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state <= ST_HOLD;
                    end else if (target_match) begin
                        state  <= ST_DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else if (tick) begin
                        prescaler <= '0;
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Prescaler is untouched here so a resume keeps the tick phase.
                    if (bus.stop) begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                    end else if (bus.start) begin
                        state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
